// File: rtl/byte_rx_fifo_if.sv
// byte_rx_fifo_if
// Groups the openMSP430 peripheral bus and the upstream byte stream of the
// receive FIFO into one bundle.
//   master : drives the bus request (per_addr, per_din, per_en, per_we) and
//            the byte stream (in_valid, in_data); it sees per_dout, in_ready
//            and irq.
//   slave  : the FIFO block itself, with the directions reversed.
interface byte_rx_fifo_if;
   logic [13:0] per_addr;
   logic [15:0] per_din;
   logic        per_en;
   logic [1:0]  per_we;
   logic [15:0] per_dout;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_ready;
   logic        irq;

   modport master (
      output per_addr, per_din, per_en, per_we, in_valid, in_data,
      input  per_dout, in_ready, irq
   );

   modport slave (
      input  per_addr, per_din, per_en, per_we, in_valid, in_data,
      output per_dout, in_ready, irq
   );
endinterface

// File: rtl/byte_rx_fifo.sv
// byte_rx_fifo
// Memory-mapped receive buffer. Bytes arrive over a valid/ready handshake
// and are stored in a 2^AW-entry FIFO. The CPU reads them through four word
// registers: STATUS (+0), DATA (+2, read pops), CTRL (+4) and COUNT (+6).
// A level interrupt is raised when the fill reaches the software threshold.
// Ports:
//   mclk     system clock, rising edge
//   puc_rst  synchronous active-high reset
//   bus      peripheral bus + byte stream + irq (byte_rx_fifo_if.slave)
module byte_rx_fifo #(
   parameter logic [14:0] BASE_ADDR = 15'h00c8,
   parameter int          DEC_WD    = 3,
   parameter int          AW        = 3
) (
   input  logic          mclk,
   input  logic          puc_rst,
   byte_rx_fifo_if.slave bus
);

   localparam logic [AW:0] DEPTH      = {1'b1, {AW{1'b0}}};
   localparam logic [1:0]  OFS_STATUS = 2'd0;
   localparam logic [1:0]  OFS_DATA   = 2'd1;
   localparam logic [1:0]  OFS_CTRL   = 2'd2;
   localparam logic [1:0]  OFS_COUNT  = 2'd3;

   // State
   logic [7:0]    mem_r [0:(1 << AW) - 1];
   logic [AW-1:0] wr_ptr_r, rd_ptr_r;
   logic [AW:0]   count_r;
   logic          overflow_r;
   logic          en_r, ien_r, drop_r;
   logic [3:0]    thresh_r;
   logic          in_ready_r, irq_r;

   // Decode and datapath
   logic          sel_s, rd_s, wr_s;
   logic [1:0]    ofs_s;
   logic          stat_wr_s, ctrl_wr_s, data_rd_s, flush_s;
   logic          empty_s, full_s, push_s, pop_s, drop_byte_s;
   logic [AW-1:0] wr_ptr_nxt_s, rd_ptr_nxt_s;
   logic [AW:0]   count_nxt_s;
   logic          overflow_nxt_s, en_nxt_s, ien_nxt_s, drop_nxt_s;
   logic [3:0]    thresh_nxt_s, eff_thresh_s;
   logic [4:0]    count_ext_s;
   logic          full_nxt_s, in_ready_nxt_s, irq_nxt_s;
   logic [15:0]   per_dout_s;

   assign sel_s     = bus.per_en & (bus.per_addr[13:DEC_WD-1] == BASE_ADDR[14:DEC_WD]);
   assign rd_s      = sel_s & (bus.per_we == 2'b00);
   assign wr_s      = sel_s & (bus.per_we != 2'b00);
   assign ofs_s     = bus.per_addr[1:0];
   assign stat_wr_s = wr_s & (ofs_s == OFS_STATUS);
   assign ctrl_wr_s = wr_s & (ofs_s == OFS_CTRL);
   assign data_rd_s = rd_s & (ofs_s == OFS_DATA);
   assign flush_s   = ctrl_wr_s & bus.per_din[3];

   assign empty_s = (count_r == {(AW+1){1'b0}});
   assign full_s  = (count_r == DEPTH);
   // in_ready_r already reflects full in normal mode; the extra ~full_s
   // keeps drop mode (where in_ready stays high) from writing past the end.
   assign push_s      = bus.in_valid & in_ready_r & ~full_s;
   assign pop_s       = data_rd_s & ~empty_s;
   assign drop_byte_s = bus.in_valid & en_r & drop_r & full_s;

   // Next-state computation for pointers, occupancy, CTRL and the flags
   // derived from them, so in_ready and irq can be registered.
   always_comb begin
      wr_ptr_nxt_s   = wr_ptr_r;
      rd_ptr_nxt_s   = rd_ptr_r;
      count_nxt_s    = count_r;
      overflow_nxt_s = overflow_r;
      en_nxt_s       = en_r;
      ien_nxt_s      = ien_r;
      drop_nxt_s     = drop_r;
      thresh_nxt_s   = thresh_r;

      // Flush wins over any push or pop on the same edge.
      if (flush_s) begin
         wr_ptr_nxt_s = {AW{1'b0}};
         rd_ptr_nxt_s = {AW{1'b0}};
         count_nxt_s  = {(AW+1){1'b0}};
      end else begin
         if (push_s) begin
            wr_ptr_nxt_s = wr_ptr_r + AW'(1'b1);
         end else begin
            wr_ptr_nxt_s = wr_ptr_r;
         end
         if (pop_s) begin
            rd_ptr_nxt_s = rd_ptr_r + AW'(1'b1);
         end else begin
            rd_ptr_nxt_s = rd_ptr_r;
         end
         case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + (AW+1)'(1'b1);
            2'b01:   count_nxt_s = count_r - (AW+1)'(1'b1);
            default: count_nxt_s = count_r;
         endcase
      end

      if (ctrl_wr_s) begin
         en_nxt_s     = bus.per_din[0];
         ien_nxt_s    = bus.per_din[1];
         drop_nxt_s   = bus.per_din[2];
         thresh_nxt_s = bus.per_din[11:8];
      end else begin
         en_nxt_s     = en_r;
         ien_nxt_s    = ien_r;
         drop_nxt_s   = drop_r;
         thresh_nxt_s = thresh_r;
      end

      // A new drop on the clearing edge stays visible rather than being lost.
      if (drop_byte_s) begin
         overflow_nxt_s = 1'b1;
      end else if (stat_wr_s & bus.per_din[2]) begin
         overflow_nxt_s = 1'b0;
      end else begin
         overflow_nxt_s = overflow_r;
      end
   end

   // Registered in_ready / irq from next state; threshold 0 acts as 1, and
   // thresholds above the depth can never be met.
   always_comb begin
      eff_thresh_s   = (thresh_nxt_s == 4'd0) ? 4'd1 : thresh_nxt_s;
      count_ext_s    = 5'(count_nxt_s);
      full_nxt_s     = (count_nxt_s == DEPTH);
      in_ready_nxt_s = en_nxt_s & (drop_nxt_s | ~full_nxt_s);
      irq_nxt_s      = ien_nxt_s & (count_ext_s >= {1'b0, eff_thresh_s});
   end

   // Control and status state, synchronous reset.
   always_ff @(posedge mclk) begin
      if (puc_rst) begin
         wr_ptr_r   <= {AW{1'b0}};
         rd_ptr_r   <= {AW{1'b0}};
         count_r    <= {(AW+1){1'b0}};
         overflow_r <= 1'b0;
         en_r       <= 1'b0;
         ien_r      <= 1'b0;
         drop_r     <= 1'b0;
         thresh_r   <= 4'd0;
         in_ready_r <= 1'b0;
         irq_r      <= 1'b0;
      end else begin
         wr_ptr_r   <= wr_ptr_nxt_s;
         rd_ptr_r   <= rd_ptr_nxt_s;
         count_r    <= count_nxt_s;
         overflow_r <= overflow_nxt_s;
         en_r       <= en_nxt_s;
         ien_r      <= ien_nxt_s;
         drop_r     <= drop_nxt_s;
         thresh_r   <= thresh_nxt_s;
         in_ready_r <= in_ready_nxt_s;
         irq_r      <= irq_nxt_s;
      end
   end

   // FIFO storage; contents need no reset.
   always_ff @(posedge mclk) begin
      if (push_s & ~flush_s & ~puc_rst) begin
         mem_r[wr_ptr_r] <= bus.in_data;
      end
   end

   // Read mux; only a selected read cycle drives the bus.
   always_comb begin
      per_dout_s = 16'h0000;
      if (rd_s) begin
         case (ofs_s)
            OFS_STATUS: per_dout_s = {12'h000, irq_r, overflow_r, full_s, ~empty_s};
            OFS_DATA:   per_dout_s = empty_s ? 16'h0000 : {8'h00, mem_r[rd_ptr_r]};
            OFS_CTRL:   per_dout_s = {4'h0, thresh_r, 5'b00000, drop_r, ien_r, en_r};
            OFS_COUNT:  per_dout_s = 16'(count_r);
            default:    per_dout_s = 16'h0000;
         endcase
      end else begin
         per_dout_s = 16'h0000;
      end
   end

   assign bus.per_dout = per_dout_s;
   assign bus.in_ready = in_ready_r;
   assign bus.irq      = irq_r;

endmodule

// File: tb/tb_byte_rx_fifo.sv
module tb_byte_rx_fifo;

   localparam int          DEPTH = 8;
   localparam logic [13:0] A_ST  = 14'h0064;
   localparam logic [13:0] A_DA  = 14'h0065;
   localparam logic [13:0] A_CT  = 14'h0066;
   localparam logic [13:0] A_CN  = 14'h0067;

   logic mclk;
   logic puc_rst;
   byte_rx_fifo_if bus_if ();

   byte_rx_fifo #(.BASE_ADDR(15'h00c8), .DEC_WD(3), .AW(3)) dut (
      .mclk    (mclk),
      .puc_rst (puc_rst),
      .bus     (bus_if)
   );

   initial mclk = 1'b0;
   always #5 mclk = ~mclk;

   int checks = 0;
   int errors = 0;

   // Reference model
   int         m_cnt = 0;
   bit         m_en = 0, m_ien = 0, m_drop = 0;
   int         m_thr = 0;
   logic [7:0] exp_q[$];

   typedef struct {
      bit          we;
      logic [13:0] addr;
      logic [15:0] wdata;
      logic [15:0] exp;
   } vec_t;
   vec_t vecs [15];

   function automatic bit pred_ready();
      return m_en && (m_drop || m_cnt < DEPTH);
   endfunction

   function automatic bit pred_irq();
      int eff;
      eff = (m_thr == 0) ? 1 : m_thr;
      return m_ien && (m_cnt >= eff);
   endfunction

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_outs();
      check("in_ready", {15'h0, bus_if.in_ready}, {15'h0, pred_ready()});
      check("irq", {15'h0, bus_if.irq}, {15'h0, pred_irq()});
   endtask

   task automatic wr_reg(input logic [13:0] addr, input logic [15:0] d);
      bus_if.per_en   = 1'b1;
      bus_if.per_we   = 2'b11;
      bus_if.per_addr = addr;
      bus_if.per_din  = d;
      @(posedge mclk);
      #1;
      bus_if.per_en = 1'b0;
      bus_if.per_we = 2'b00;
      if (addr == A_CT) begin
         m_en   = d[0];
         m_ien  = d[1];
         m_drop = d[2];
         m_thr  = int'(d[11:8]);
         if (d[3]) begin
            exp_q.delete();
            m_cnt = 0;
         end
      end
   endtask

   task automatic rd_chk(input string name, input logic [13:0] addr, input logic [15:0] exp);
      bus_if.per_en   = 1'b1;
      bus_if.per_we   = 2'b00;
      bus_if.per_addr = addr;
      @(negedge mclk);
      check(name, bus_if.per_dout, exp);
      @(posedge mclk);
      #1;
      bus_if.per_en = 1'b0;
   endtask

   // One clock of optional DATA read and optional byte offer, checked against the model.
   task automatic cycle(input bit do_rd, input bit do_send, input logic [7:0] b);
      logic [15:0] exp_d;
      bit rdy, pre_full;
      rdy      = pred_ready();
      pre_full = (m_cnt == DEPTH);
      exp_d    = 16'h0000;
      if (m_cnt > 0) exp_d = {8'h00, exp_q[0]};
      bus_if.per_en    = do_rd;
      bus_if.per_we    = 2'b00;
      bus_if.per_addr  = A_DA;
      bus_if.in_valid  = do_send;
      bus_if.in_data   = b;
      @(negedge mclk);
      if (do_rd) check("data", bus_if.per_dout, exp_d);
      if (do_send) check("in_ready_offer", {15'h0, bus_if.in_ready}, {15'h0, rdy});
      @(posedge mclk);
      #1;
      bus_if.per_en   = 1'b0;
      bus_if.in_valid = 1'b0;
      if (do_rd && m_cnt > 0) begin
         void'(exp_q.pop_front());
         m_cnt--;
      end
      if (do_send && rdy && !pre_full) begin
         exp_q.push_back(b);
         m_cnt++;
      end
      check_outs();
   endtask

   task automatic model_reset();
      m_cnt = 0; m_en = 0; m_ien = 0; m_drop = 0; m_thr = 0;
      exp_q.delete();
   endtask

   initial begin
      bus_if.per_addr = 14'h0000;
      bus_if.per_din  = 16'h0000;
      bus_if.per_en   = 1'b0;
      bus_if.per_we   = 2'b00;
      bus_if.in_valid = 1'b0;
      bus_if.in_data  = 8'h00;
      puc_rst = 1'b1;
      repeat (2) @(posedge mclk);
      #1;
      puc_rst = 1'b0;
      check_outs();

      // Register-level vectors from reset
      vecs[0]  = '{1'b0, A_ST, 16'h0000, 16'h0000};
      vecs[1]  = '{1'b0, A_DA, 16'h0000, 16'h0000};
      vecs[2]  = '{1'b0, A_CT, 16'h0000, 16'h0000};
      vecs[3]  = '{1'b0, A_CN, 16'h0000, 16'h0000};
      vecs[4]  = '{1'b1, A_CT, 16'hFFFF, 16'h0000};
      vecs[5]  = '{1'b0, A_CT, 16'h0000, 16'h0F07};
      vecs[6]  = '{1'b0, A_ST, 16'h0000, 16'h0000};
      vecs[7]  = '{1'b1, A_CN, 16'hFFFF, 16'h0000};
      vecs[8]  = '{1'b0, A_CN, 16'h0000, 16'h0000};
      vecs[9]  = '{1'b1, A_DA, 16'h00AB, 16'h0000};
      vecs[10] = '{1'b0, A_ST, 16'h0000, 16'h0000};
      vecs[11] = '{1'b0, 14'h0068, 16'h0000, 16'h0000};
      vecs[12] = '{1'b0, 14'h0063, 16'h0000, 16'h0000};
      vecs[13] = '{1'b1, A_CT, 16'h0000, 16'h0000};
      vecs[14] = '{1'b0, A_CT, 16'h0000, 16'h0000};
      for (int i = 0; i < 15; i++) begin
         if (vecs[i].we) wr_reg(vecs[i].addr, vecs[i].wdata);
         else            rd_chk($sformatf("vec%0d", i), vecs[i].addr, vecs[i].exp);
         check_outs();
      end

      // Basic stream of three bytes
      wr_reg(A_CT, 16'h0001);
      check_outs();
      cycle(0, 1, 8'h11);
      cycle(0, 1, 8'h22);
      cycle(0, 1, 8'h33);
      rd_chk("count3", A_CN, 16'h0003);
      for (int i = 0; i < 4; i++) cycle(1, 0, 8'h00);
      rd_chk("status_empty", A_ST, 16'h0000);

      // Fill to depth, back-pressure, wrap
      for (int i = 0; i < 8; i++) cycle(0, 1, 8'hA0 + 8'(i));
      cycle(0, 1, 8'hA8);
      rd_chk("status_full", A_ST, 16'h0003);
      cycle(1, 0, 8'h00);
      cycle(0, 1, 8'hA8);
      cycle(0, 1, 8'hA9);
      for (int i = 0; i < 9; i++) cycle(1, 0, 8'h00);

      // Drop mode overflow
      wr_reg(A_CT, 16'h0005);
      check_outs();
      for (int i = 0; i < 9; i++) cycle(0, 1, 8'hB0 + 8'(i));
      rd_chk("status_ovf", A_ST, 16'h0007);
      wr_reg(A_ST, 16'h0004);
      rd_chk("status_ovf_clr", A_ST, 16'h0003);
      rd_chk("count_after_clr", A_CN, 16'h0008);

      // Simultaneous pop and push
      wr_reg(A_CT, 16'h0001);
      check_outs();
      cycle(1, 1, 8'hC0);
      rd_chk("count7", A_CN, 16'h0007);
      for (int i = 0; i < 3; i++) cycle(1, 0, 8'h00);
      cycle(1, 1, 8'hC1);
      rd_chk("count4", A_CN, 16'h0004);
      for (int i = 0; i < 5; i++) cycle(1, 0, 8'h00);

      // Threshold interrupt
      wr_reg(A_CT, 16'h0303);
      check_outs();
      cycle(0, 1, 8'hD0);
      cycle(0, 1, 8'hD1);
      cycle(0, 1, 8'hD2);
      rd_chk("status_irq", A_ST, 16'h0009);
      cycle(1, 0, 8'h00);
      wr_reg(A_CT, 16'h0003);
      check_outs();
      cycle(1, 0, 8'h00);
      cycle(1, 0, 8'h00);
      cycle(0, 1, 8'hD3);
      wr_reg(A_CT, 16'h0903);
      check_outs();
      wr_reg(A_CT, 16'h0001);
      check_outs();

      // Flush with a byte on offer
      for (int i = 0; i < 4; i++) cycle(0, 1, 8'hE0 + 8'(i));
      rd_chk("count5", A_CN, 16'h0005);
      bus_if.in_valid = 1'b1;
      bus_if.in_data  = 8'hEE;
      wr_reg(A_CT, 16'h000D);
      bus_if.in_valid = 1'b0;
      check_outs();
      rd_chk("count_flush", A_CN, 16'h0000);
      rd_chk("ctrl_flush", A_CT, 16'h0005);
      cycle(1, 0, 8'h00);

      // Reset mid-stream
      wr_reg(A_CT, 16'h0001);
      cycle(0, 1, 8'hF0);
      cycle(0, 1, 8'hF1);
      bus_if.in_valid = 1'b1;
      bus_if.in_data  = 8'h77;
      puc_rst = 1'b1;
      @(posedge mclk);
      #1;
      puc_rst = 1'b0;
      bus_if.in_valid = 1'b0;
      model_reset();
      check_outs();
      rd_chk("rst_status", A_ST, 16'h0000);
      rd_chk("rst_count", A_CN, 16'h0000);
      rd_chk("rst_ctrl", A_CT, 16'h0000);
      cycle(1, 0, 8'h00);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/byte_rx_fifo.md
# byte_rx_fifo

Memory-mapped receive buffer for the simulation I/O path. It accepts a stream of bytes from an upstream byte source over a valid/ready handshake, such as the testbench input-file reader. It holds those bytes in a 2^AW-entry FIFO and exposes them to the CPU through four word registers on the openMSP430 peripheral bus. It also raises a level interrupt once the fill reaches a software-set threshold, so firmware can consume input in bursts instead of polling one byte at a time.

## Interface
Parameters:
- BASE_ADDR, 15'h00c8, register base byte address, aligned to 2^DEC_WD
- DEC_WD, 3, address decode width (four word registers)
- AW, 3, FIFO address width; depth = 2^AW, legal range 1..4

Ports:
- mclk  input  1  system clock; all state updates on its rising edge
- puc_rst  input  1  reset, synchronous, active-high
- per_addr  input  14  peripheral word address
- per_din  input  16  write data
- per_en  input  1  bus access strobe
- per_we  input  2  byte write enables; 2'b00 = read
- per_dout  output  16  read data; 0 when not selected
- in_valid  input  1  upstream byte valid
- in_data  input  8  upstream byte
- in_ready  output  1  block accepts in_data this cycle
- irq  output  1  level interrupt request

## Operation
- Select: per_en and per_addr[13:DEC_WD-1] == BASE_ADDR[14:DEC_WD]. Word offset is per_addr[1:0].
- Writes act on any per_we != 0. All registers are treated as 16-bit.
- STATUS (+0x0), read:
  - [0] not_empty
  - [1] full
  - [2] overflow, sticky
  - [3] irq
  - other bits 0
  - Writing 1 to bit 2 clears overflow; writes to all other bits are ignored.
- DATA (+0x2), read:
  - Returns {8'h00, head byte} and pops one entry at that clock edge.
  - When the FIFO is empty it returns 16'h0000, does not pop, and does not underflow.
  - Writes are ignored.
- CTRL (+0x4), R/W:
  - [0] en: accept input
  - [1] ien: interrupt enable
  - [2] drop: drop mode
  - [3] flush: write-only, self-clearing, reads 0
  - [11:8] thresh
  - other bits read 0
- COUNT (+0x6), read-only: {zero-pad, count[AW:0]}, the current occupancy.
- FIFO storage:
  - wr_ptr and rd_ptr are AW bits wide and wrap modulo 2^AW.
  - count is AW+1 bits wide and ranges 0..2^AW.
  - full = (count == 2^AW); empty = (count == 0).
- in_ready:
  - Normal mode: en & ~full.
  - Drop mode: equals en, so the upstream never stalls.
  - Push when in_valid & in_ready & ~full.
  - In drop mode, in_valid & en & full discards the byte and sets overflow.
- Push and pop in the same cycle: both take effect and count is unchanged. Push into a full FIFO is never allowed in that cycle; in_ready is computed from the registered full.
- Flush: on the write edge it zeroes wr_ptr, rd_ptr and count. Flush takes priority over a simultaneous push or pop, and any byte presented on that edge is lost. Overflow is not cleared by flush.
- Writing CTRL.en = 0 stops acceptance only; FIFO contents remain readable.
- irq = ien & (count >= eff_thresh), where eff_thresh = max(thresh, 1). If thresh > 2^AW, irq never asserts.

## Timing
- Reset values:
  - ptrs, count, overflow, CTRL all 0
  - in_ready = 0, irq = 0, per_dout = 0
  - FIFO RAM contents are don't-care
- per_dout is combinational from the current per_addr and state, valid in the same cycle as per_en.
- A DATA read returns the pre-pop head; the pop is visible from the next cycle.
- Pushed byte: visible in STATUS/COUNT and readable via DATA one cycle after the accepting edge.
- Latency from upstream handshake to earliest DATA read is 1 cycle. There is no combinational bypass.
- irq and in_ready are registered-state functions: they update one cycle after the push, pop or CTRL write that changes them.
- Reset mid-transfer: a byte offered on the reset edge is not accepted; the FIFO is emptied.

## Test plan
- Reset, then write CTRL = 0x0001. Drive bytes 0x11, 0x22, 0x33 back-to-back. Expected:
  - COUNT reads 3.
  - DATA reads return 0x0011, 0x0022, 0x0033, then 0x0000.
  - STATUS ends at 0x0000.
- Depth 8, en = 1, stream 10 bytes 0xA0..0xA9 in normal mode. Expected:
  - in_ready drops after 8 accepts; STATUS = 0x0003.
  - After one DATA read (0x00A0), in_ready rises and 0xA8 is accepted next.
  - Order stays intact across pointer wrap.
- Drop mode (CTRL = 0x0005): push 9 bytes into depth 8. Expected:
  - 9th byte is dropped and STATUS[2] = 1.
  - Writing STATUS = 0x0004 clears overflow; contents are unchanged.
- FIFO full, DATA read plus in_valid on the same edge. Expected: the push is refused and count becomes 7. With count = 4, the same simultaneous read and push leaves count at 4.
- CTRL = 0x0303 (thresh 3, ien). Expected:
  - irq = 0 at count 2.
  - irq rises the cycle after the 3rd push.
  - irq falls the cycle after the pop to count 2.
  - thresh 0 behaves as thresh 1.
- With 5 bytes queued, write CTRL = 0x000D while in_valid = 1. Expected:
  - COUNT = 0 and the offered byte is lost.
  - CTRL reads back 0x0005.
- puc_rst asserted mid-stream. Expected: everything returns to reset values on that edge.
